// File: rtl/sprite_multi_pkg.sv
// Shared constants, register field codes and sizing helpers for the sprite engine.
package sprite_multi_pkg;

  // Scale register width and the fixed-point divisor shift (scale 8 == 1:1).
  localparam int unsigned SCALE_BITS     = 4;
  localparam int unsigned SCALE_DIV_BITS = 8;

  // Per-sprite register field selected by reg_address[1:0].
  typedef enum logic [1:0] {
    FIELD_X      = 2'd0,
    FIELD_Y      = 2'd1,
    FIELD_SCALE  = 2'd2,
    FIELD_ENABLE = 2'd3
  } field_e;

  // Bitmap address width for one sprite: edge^2 pixels.
  function automatic int unsigned addr_bits(int unsigned sprite_size_bits);
    return 2 * sprite_size_bits;
  endfunction

  // Bits needed to name a sprite; at least one so a 1-sprite build stays legal.
  function automatic int unsigned index_bits(int unsigned num_sprites);
    return (num_sprites > 1) ? $clog2(num_sprites) : 1;
  endfunction

endpackage

// File: rtl/sprite_channel.sv
// One sprite: staging/shadow registers, d1-d5 pixel pipeline and its bitmap RAM.
module sprite_channel
  import sprite_multi_pkg::*;
#(
  parameter int unsigned SPRITE_SIZE_BITS  = 6,
  parameter int unsigned BPP               = 8,
  parameter int unsigned OFFSET_BITS       = 16,
  parameter int unsigned TRANSPARENT_COLOR = 0,
  localparam int unsigned ADDR_BITS        = 2 * SPRITE_SIZE_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reg_we,
  input  logic [1:0]             reg_field,
  input  logic [OFFSET_BITS-1:0] reg_din,
  input  logic                   frame_start,
  input  logic                   bitmap_we,
  input  logic [ADDR_BITS-1:0]   bitmap_addr,
  input  logic [BPP-1:0]         bitmap_din,
  input  logic [OFFSET_BITS-1:0] pix_h,
  input  logic [OFFSET_BITS-1:0] pix_v,
  output logic [BPP-1:0]         ch_color,
  output logic                   ch_opaque
);

  localparam int unsigned SB   = SPRITE_SIZE_BITS;
  localparam int unsigned WIDE = OFFSET_BITS + 17;
  localparam logic [BPP-1:0] TRANSP = BPP'(TRANSPARENT_COLOR);

  logic [OFFSET_BITS-1:0] x_stage_q, y_stage_q, x_shadow_q, y_shadow_q;
  logic [SCALE_BITS-1:0]  scale_stage_q, scale_shadow_q;
  logic                   en_stage_q, en_shadow_q;

  logic signed [OFFSET_BITS:0] dx0_q, dy0_q;
  logic [SCALE_BITS-1:0]       scale_d1_q;
  logic                        en_d1_q;

  logic signed [WIDE-1:0] dx0_w, dy0_w, dx1_w, dy1_w;
  logic                   inside_d2;

  logic [SB-1:0]        dx1_q, dy1_q;
  logic [ADDR_BITS-1:0] raddr_q;
  logic [BPP-1:0]       pix_q;
  logic                 inside_d2_q, inside_d3_q, inside_d4_q;
  logic [BPP-1:0]       ch_color_q;
  logic                 ch_opaque_q;

  logic [BPP-1:0] mem [2**ADDR_BITS];

  // CPU writes land in staging; shadows copy staging at frame start only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_stage_q      <= '0;
      y_stage_q      <= '0;
      scale_stage_q  <= '0;
      en_stage_q     <= 1'b0;
      x_shadow_q     <= '0;
      y_shadow_q     <= '0;
      scale_shadow_q <= '0;
      en_shadow_q    <= 1'b0;
    end else begin
      // Shadow samples the pre-write staging value when both happen together.
      if (frame_start) begin
        x_shadow_q     <= x_stage_q;
        y_shadow_q     <= y_stage_q;
        scale_shadow_q <= scale_stage_q;
        en_shadow_q    <= en_stage_q;
      end
      if (reg_we) begin
        case (field_e'(reg_field))
          FIELD_X:      x_stage_q     <= reg_din;
          FIELD_Y:      y_stage_q     <= reg_din;
          FIELD_SCALE:  scale_stage_q <= reg_din[SCALE_BITS-1:0];
          FIELD_ENABLE: en_stage_q    <= reg_din[0];
          default:      ;
        endcase
      end
    end
  end

  // d2 combinational scaling: sign-extend, apply scale, divide by 256.
  always_comb begin
    dx0_w     = {{16{dx0_q[OFFSET_BITS]}}, dx0_q};
    dy0_w     = {{16{dy0_q[OFFSET_BITS]}}, dy0_q};
    dx1_w     = (dx0_w <<< scale_d1_q) >>> SCALE_DIV_BITS;
    dy1_w     = (dy0_w <<< scale_d1_q) >>> SCALE_DIV_BITS;
    // Upper bits all zero means 0 <= d1 < SPRITE_SIZE.
    inside_d2 = en_d1_q && !dx0_q[OFFSET_BITS] && !dy0_q[OFFSET_BITS] &&
                (dx1_w[WIDE-1:SB] == '0) && (dy1_w[WIDE-1:SB] == '0);
  end

  // Pipeline stages d1..d5, all cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dx0_q       <= '0;
      dy0_q       <= '0;
      scale_d1_q  <= '0;
      en_d1_q     <= 1'b0;
      dx1_q       <= '0;
      dy1_q       <= '0;
      inside_d2_q <= 1'b0;
      raddr_q     <= '0;
      inside_d3_q <= 1'b0;
      pix_q       <= '0;
      inside_d4_q <= 1'b0;
      ch_color_q  <= '0;
      ch_opaque_q <= 1'b0;
    end else begin
      dx0_q       <= $signed({1'b0, pix_h}) - $signed({1'b0, x_shadow_q});
      dy0_q       <= $signed({1'b0, pix_v}) - $signed({1'b0, y_shadow_q});
      scale_d1_q  <= scale_shadow_q;
      en_d1_q     <= en_shadow_q;
      dx1_q       <= dx1_w[SB-1:0];
      dy1_q       <= dy1_w[SB-1:0];
      inside_d2_q <= inside_d2;
      raddr_q     <= {dy1_q, dx1_q};
      inside_d3_q <= inside_d2_q;
      pix_q       <= mem[raddr_q];
      inside_d4_q <= inside_d3_q;
      ch_opaque_q <= inside_d4_q && (pix_q != TRANSP);
      ch_color_q  <= (inside_d4_q && (pix_q != TRANSP)) ? pix_q : '0;
    end
  end

  // Bitmap RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (bitmap_we) begin
      mem[bitmap_addr] <= bitmap_din;
    end
  end

  assign ch_color  = ch_color_q;
  assign ch_opaque = ch_opaque_q;

endmodule

// File: rtl/sprite_multi.sv
// Multi-sprite engine top: bus decode, per-sprite channels, priority mux and output register.
module sprite_multi
  import sprite_multi_pkg::*;
#(
  parameter int unsigned NUM_SPRITES       = 4,
  parameter int unsigned SPRITE_SIZE_BITS  = 6,
  parameter int unsigned BPP               = 8,
  parameter int unsigned OFFSET_BITS       = 16,
  parameter int unsigned TRANSPARENT_COLOR = 0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [31:0]     bitmap_length,
  input  logic [31:0]     bitmap_address,
  input  logic [BPP-1:0]  bitmap_din,
  input  logic            bitmap_we,
  input  logic [31:0]     reg_address,
  input  logic [31:0]     reg_din,
  input  logic            reg_we,
  input  logic [31:0]     count_h,
  input  logic [31:0]     count_v,
  output logic [BPP-1:0]  color,
  output logic            opaque
);

  localparam int unsigned ADDR_BITS = addr_bits(SPRITE_SIZE_BITS);

  logic [29:0]             reg_idx;
  logic [31-ADDR_BITS:0]   bm_idx;
  logic                    frame_start;
  logic [NUM_SPRITES-1:0]  ch_reg_we, ch_bm_we, ch_opaque;
  logic [BPP-1:0]          ch_color [NUM_SPRITES];
  logic [BPP-1:0]          color_d, color_q;
  logic                    opaque_d, opaque_q;
  logic                    unused_bits;

  assign bitmap_length = 32'(NUM_SPRITES) << ADDR_BITS;
  assign reg_idx       = reg_address[31:2];
  assign bm_idx        = bitmap_address[31:ADDR_BITS];
  assign frame_start   = (count_h == '0) && (count_v == '0);
  assign unused_bits   = ^reg_din[31:OFFSET_BITS];

  // Full-width index compare: out-of-range sprite indices select no channel.
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_ch
    assign ch_reg_we[g] = reg_we && (reg_idx == 30'(g));
    assign ch_bm_we[g]  = bitmap_we && (bm_idx == (32 - ADDR_BITS)'(g));

    sprite_channel #(
      .SPRITE_SIZE_BITS (SPRITE_SIZE_BITS),
      .BPP              (BPP),
      .OFFSET_BITS      (OFFSET_BITS),
      .TRANSPARENT_COLOR(TRANSPARENT_COLOR)
    ) u_channel (
      .clk        (clk),
      .reset      (reset),
      .reg_we     (ch_reg_we[g]),
      .reg_field  (reg_address[1:0]),
      .reg_din    (reg_din[OFFSET_BITS-1:0]),
      .frame_start(frame_start),
      .bitmap_we  (ch_bm_we[g]),
      .bitmap_addr(bitmap_address[ADDR_BITS-1:0]),
      .bitmap_din (bitmap_din),
      .pix_h      (count_h[OFFSET_BITS-1:0]),
      .pix_v      (count_v[OFFSET_BITS-1:0]),
      .ch_color   (ch_color[g]),
      .ch_opaque  (ch_opaque[g])
    );
  end

  // Fixed priority: scan from highest index down so the lowest opaque channel wins.
  always_comb begin
    color_d  = '0;
    opaque_d = 1'b0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (ch_opaque[i]) begin
        color_d  = ch_color[i];
        opaque_d = 1'b1;
      end
    end
  end

  // d6 output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      color_q  <= '0;
      opaque_q <= 1'b0;
    end else begin
      color_q  <= color_d;
      opaque_q <= opaque_d;
    end
  end

  assign color  = color_q;
  assign opaque = opaque_q;

endmodule

// File: tb/tb_sprite_multi.sv
// Scoreboard bench for sprite_multi: a behavioural model predicts each pixel at drive time.
`timescale 1ns/1ps
module tb_sprite_multi;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] bitmap_length;
  logic [31:0] bitmap_address = '0;
  logic [7:0]  bitmap_din = '0;
  logic        bitmap_we = 1'b0;
  logic [31:0] reg_address = '0;
  logic [31:0] reg_din = '0;
  logic        reg_we = 1'b0;
  logic [31:0] count_h = 32'd1;
  logic [31:0] count_v = 32'd1;
  logic [7:0]  color;
  logic        opaque;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] color;
    logic       op;
    string      name;
  } exp_t;

  typedef struct {
    int    h;
    int    v;
    bit    we;
    int    addr;
    int    din;
    string name;
  } stim_t;

  exp_t  exp_q[$];
  stim_t sq[$];

  // Model state: staging, shadow and bitmap contents.
  int         st_x[NS], st_y[NS], st_s[NS], st_en[NS];
  int         sh_x[NS], sh_y[NS], sh_s[NS], sh_en[NS];
  logic [7:0] bm[NS][4096];

  sprite_multi dut (
    .clk           (clk),
    .reset         (reset),
    .bitmap_length (bitmap_length),
    .bitmap_address(bitmap_address),
    .bitmap_din    (bitmap_din),
    .bitmap_we     (bitmap_we),
    .reg_address   (reg_address),
    .reg_din       (reg_din),
    .reg_we        (reg_we),
    .count_h       (count_h),
    .count_v       (count_v),
    .color         (color),
    .opaque        (opaque)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(int h, int v, string name);
    exp_t   r;
    longint dx, dy, dx1, dy1;
    logic [7:0] pix;
    r.color = 8'h00;
    r.op    = 1'b0;
    r.name  = name;
    for (int i = 0; i < NS; i++) begin
      if (!r.op && sh_en[i] != 0) begin
        dx = longint'(h & 32'hffff) - longint'(sh_x[i]);
        dy = longint'(v & 32'hffff) - longint'(sh_y[i]);
        if (dx >= 0 && dy >= 0) begin
          dx1 = (dx << sh_s[i]) >> 8;
          dy1 = (dy << sh_s[i]) >> 8;
          if (dx1 < 64 && dy1 < 64) begin
            pix = bm[i][int'(dy1 * 64 + dx1)];
            if (pix != 8'h00) begin
              r.color = pix;
              r.op    = 1'b1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      st_x[i] = 0; st_y[i] = 0; st_s[i] = 0; st_en[i] = 0;
      sh_x[i] = 0; sh_y[i] = 0; sh_s[i] = 0; sh_en[i] = 0;
    end
  endfunction

  function automatic void add_px(int h, int v, string name);
    sq.push_back('{h: h, v: v, we: 1'b0, addr: 0, din: 0, name: name});
  endfunction

  function automatic void add_wr(int idx, int field, int val);
    sq.push_back('{h: 1, v: 1, we: 1'b1, addr: (idx << 2) | field, din: val, name: "wr"});
  endfunction

  function automatic void add_tail();
    for (int i = 0; i < 6; i++) add_px(1, 1, "idle");
  endfunction

  // Drive one pixel cycle, predict its output, and pop the prediction due now.
  task automatic step(input stim_t s, output bit popped, output exp_t e);
    exp_t n;
    int   idx;
    count_h     = s.h;
    count_v     = s.v;
    reg_we      = s.we;
    reg_address = s.addr;
    reg_din     = s.din;
    n = model(s.h, s.v, s.name);
    exp_q.push_back(n);
    if (s.h == 0 && s.v == 0) begin
      for (int i = 0; i < NS; i++) begin
        sh_x[i] = st_x[i]; sh_y[i] = st_y[i]; sh_s[i] = st_s[i]; sh_en[i] = st_en[i];
      end
    end
    idx = s.addr >> 2;
    if (s.we && idx < NS) begin
      case (s.addr & 3)
        0: st_x[idx]  = s.din & 32'hffff;
        1: st_y[idx]  = s.din & 32'hffff;
        2: st_s[idx]  = s.din & 15;
        default: st_en[idx] = s.din & 1;
      endcase
    end
    @(posedge clk);
    #1;
    reg_we = 1'b0;
    popped = 1'b0;
    e      = n;
    if (exp_q.size() >= 6) begin
      e      = exp_q.pop_front();
      popped = 1'b1;
    end
  endtask

  // Bitmap writes break scoreboard alignment, so in-flight predictions are dropped.
  task automatic bm_write(input int addr, input int val);
    count_h        = 1;
    count_v        = 1;
    bitmap_address = addr;
    bitmap_din     = val[7:0];
    bitmap_we      = 1'b1;
    @(posedge clk);
    #1;
    bitmap_we = 1'b0;
    if ((addr >> 12) < NS) bm[addr >> 12][addr & 4095] = val[7:0];
    exp_q.delete();
  endtask

  task automatic test_reset();
    bit   p;
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (color !== 8'h00 || opaque !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: color=%h opaque=%b, expected 00/0", color, opaque);
    end
    checks++;
    if (bitmap_length !== 32'd16384) begin
      errors++;
      $display("FAIL bitmap_length: got %0d, expected 16384", bitmap_length);
    end
    reset = 1'b1;
    // Clear RAM of the two sprites used below so unwritten pixels are known.
    for (int a = 0; a < 8192; a++) begin
      bitmap_address = a;
      bitmap_din     = 8'h00;
      bitmap_we      = 1'b1;
      @(posedge clk);
      #1;
    end
    bitmap_we = 1'b0;
    exp_q.delete();
    sq.delete();
    for (int v = 0; v < 3; v++)
      for (int h = 0; h < 12; h++) add_px(h * 16, v * 40, "idle_frame");
    add_tail();
    foreach (sq[i]) begin
      step(sq[i], p, e);
      if (p) begin
        checks++;
        if (color !== e.color || opaque !== e.op) begin
          errors++;
          $display("FAIL %s: color=%h opaque=%b, expected color=%h opaque=%b",
                   e.name, color, opaque, e.color, e.op);
        end
      end
    end
  endtask

  task automatic test_basic();
    bit   p;
    exp_t e;
    bm_write(0, 8'h55);
    bm_write(4 << 12, 8'h99);  // out-of-range sprite index: ignored
    sq.delete();
    add_wr(0, 0, 100); add_wr(0, 1, 50); add_wr(0, 2, 8); add_wr(0, 3, 1);
    add_wr(4, 0, 7);           // out-of-range sprite index: ignored
    add_px(100, 50, "before_frame");
    add_px(0, 0, "frame");
    add_px(100, 50, "hit");
    add_px(99, 50, "left_of");
    add_px(164, 50, "right_of");
    add_px(100, 49, "above");
    add_px(100, 114, "below");
    add_px(100 + 65536, 50, "trunc_h");
    add_px(100, 50, "hit2");
    add_tail();
    foreach (sq[i]) begin
      step(sq[i], p, e);
      if (p) begin
        checks++;
        if (color !== e.color || opaque !== e.op) begin
          errors++;
          $display("FAIL %s: color=%h opaque=%b, expected color=%h opaque=%b",
                   e.name, color, opaque, e.color, e.op);
        end
      end
    end
  endtask

  task automatic test_magnify();
    bit   p;
    exp_t e;
    bm_write(1, 8'h22);
    sq.delete();
    add_wr(0, 2, 7);
    add_px(0, 0, "frame");
    add_px(102, 50, "mag_102");
    add_px(103, 50, "mag_103");
    add_px(101, 50, "mag_101");
    add_px(104, 50, "mag_104");
    add_px(227, 50, "mag_edge");
    add_wr(0, 2, 8);
    add_px(0, 0, "frame");
    add_px(101, 50, "unity_101");
    add_tail();
    foreach (sq[i]) begin
      step(sq[i], p, e);
      if (p) begin
        checks++;
        if (color !== e.color || opaque !== e.op) begin
          errors++;
          $display("FAIL %s: color=%h opaque=%b, expected color=%h opaque=%b",
                   e.name, color, opaque, e.color, e.op);
        end
      end
    end
  endtask

  task automatic test_shadow();
    bit   p;
    exp_t e;
    sq.delete();
    add_wr(0, 0, 200);
    add_px(100, 50, "old_x");
    add_px(200, 50, "new_x_early");
    // Write x=100 in the same cycle as frame start: lands one frame later.
    sq.push_back('{h: 0, v: 0, we: 1'b1, addr: 0, din: 100, name: "frame_wr"});
    add_px(200, 50, "new_x");
    add_px(100, 50, "old_x_gone");
    add_px(0, 0, "frame");
    add_px(100, 50, "back_x");
    add_px(200, 50, "x200_gone");
    add_tail();
    foreach (sq[i]) begin
      step(sq[i], p, e);
      if (p) begin
        checks++;
        if (color !== e.color || opaque !== e.op) begin
          errors++;
          $display("FAIL %s: color=%h opaque=%b, expected color=%h opaque=%b",
                   e.name, color, opaque, e.color, e.op);
        end
      end
    end
  endtask

  task automatic test_priority();
    bit   p;
    exp_t e;
    bm_write(1 << 12, 8'h77);
    sq.delete();
    add_wr(1, 0, 100); add_wr(1, 1, 50); add_wr(1, 2, 8); add_wr(1, 3, 1);
    add_px(0, 0, "frame");
    add_px(100, 50, "prio_s0");
    add_px(102, 50, "both_clear");
    add_tail();
    foreach (sq[i]) begin
      step(sq[i], p, e);
      if (p) begin
        checks++;
        if (color !== e.color || opaque !== e.op) begin
          errors++;
          $display("FAIL %s: color=%h opaque=%b, expected color=%h opaque=%b",
                   e.name, color, opaque, e.color, e.op);
        end
      end
    end
    bm_write(0, 8'h00);
    sq.delete();
    add_px(100, 50, "transp_s1");
    add_px(101, 50, "s0_over_s1");
    add_tail();
    foreach (sq[i]) begin
      step(sq[i], p, e);
      if (p) begin
        checks++;
        if (color !== e.color || opaque !== e.op) begin
          errors++;
          $display("FAIL %s: color=%h opaque=%b, expected color=%h opaque=%b",
                   e.name, color, opaque, e.color, e.op);
        end
      end
    end
  endtask

  task automatic test_reset_midline();
    bit   p;
    exp_t e;
    sq.delete();
    for (int i = 0; i < 8; i++) add_px(101, 50, "pre_reset");
    foreach (sq[i]) begin
      step(sq[i], p, e);
      if (p) begin
        checks++;
        if (color !== e.color || opaque !== e.op) begin
          errors++;
          $display("FAIL %s: color=%h opaque=%b, expected color=%h opaque=%b",
                   e.name, color, opaque, e.color, e.op);
        end
      end
    end
    checks++;
    if (opaque !== 1'b1) begin
      errors++;
      $display("FAIL opaque_before_reset: opaque=%b, expected 1", opaque);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (color !== 8'h00 || opaque !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: color=%h opaque=%b, expected 00/0", color, opaque);
    end
    model_reset();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    sq.delete();
    add_px(101, 50, "post_reset");
    add_px(0, 0, "frame");
    add_px(101, 50, "post_reset_frame");
    add_wr(0, 0, 100); add_wr(0, 1, 50); add_wr(0, 2, 8); add_wr(0, 3, 1);
    add_px(101, 50, "reenabled_staged");
    add_px(0, 0, "frame");
    add_px(101, 50, "reenabled");
    add_px(100, 50, "reenabled_transp");
    add_tail();
    foreach (sq[i]) begin
      step(sq[i], p, e);
      if (p) begin
        checks++;
        if (color !== e.color || opaque !== e.op) begin
          errors++;
          $display("FAIL %s: color=%h opaque=%b, expected color=%h opaque=%b",
                   e.name, color, opaque, e.color, e.op);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < NS; i++)
      for (int a = 0; a < 4096; a++) bm[i][a] = 8'h00;
    test_reset();
    test_basic();
    test_magnify();
    test_shadow();
    test_priority();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_multi.md
Name: sprite_multi

Overview:
Multi-channel hardware sprite engine, the parametrised successor of the single-sprite block. It runs NUM_SPRITES independent sprites, each with its own bitmap, position, scale and enable. Each sprite has a transparent colour key, and overlapping sprites are resolved by fixed priority. Position and scale registers are double-buffered and update only at frame start, so there is no tearing. It sits between the CPU register/memory bus and the video output mixer, and everything runs in a single clock domain (no CDC).

Parameters:
NUM_SPRITES, 4, number of sprite channels (1..16)
SPRITE_SIZE_BITS, 6, sprite edge is 2^SPRITE_SIZE_BITS pixels
BPP, 8, bits per pixel
OFFSET_BITS, 16, width of position and counter values used
TRANSPARENT_COLOR, 0, pixel value treated as see-through

Ports:
clk  in  1  single clock (bus and pixel pipeline)
reset  in  1  asynchronous, active-low reset
bitmap_length  out  32  constant NUM_SPRITES << (2*SPRITE_SIZE_BITS)
bitmap_address  in  32  [ADDR_BITS-1:0] = pixel, upper bits = sprite index
bitmap_din  in  BPP  bitmap write data
bitmap_we  in  1  bitmap write strobe
reg_address  in  32  {sprite index, field[1:0]}; field 0=x, 1=y, 2=scale, 3=enable
reg_din  in  32  register write data
reg_we  in  1  register write strobe
count_h  in  32  current pixel column
count_v  in  32  current pixel row
color  out  BPP  composited sprite pixel
opaque  out  1  1 when color comes from any sprite

Behaviour:
- Reset (async assert, sync release):
  - color=0, opaque=0, all pipeline registers 0.
  - Staging and shadow x/y/scale/enable = 0.
  - Bitmap RAM is not cleared.
- Register writes:
  - reg_we writes the staging copy of the addressed field on the next edge.
  - x and y take reg_din[OFFSET_BITS-1:0]; scale takes [3:0]; enable takes [0].
  - A sprite index >= NUM_SPRITES is ignored.
- Shadow update:
  - In a cycle where count_h==0 and count_v==0, all shadow registers load from staging.
  - If reg_we falls in that same cycle, the shadow takes the pre-write staging value; the new value lands in the following frame.
- Bitmap writes:
  - bitmap_we writes bitmap_din to the addressed sprite's RAM.
  - A sprite index >= NUM_SPRITES is ignored.
- Pixel pipeline, fixed latency 6 (count at cycle n -> color/opaque at n+6):
  - d1: dx0 = zero-extended count_h[OFFSET_BITS-1:0] minus zero-extended x_shadow, signed OFFSET_BITS+1 bits; dy0 likewise.
  - d2:
    - dx1 = (dx0 <<< scale) >>> 8, arithmetic, in an intermediate OFFSET_BITS+17 bits wide; dy1 likewise.
    - inside = enable && dx0>=0 && dy0>=0 && dx1<SPRITE_SIZE && dy1<SPRITE_SIZE.
    - scale 8 = 1:1; scale <8 magnifies; scale >8 shrinks.
  - d3: raddr = dy1[SB-1:0]*SPRITE_SIZE + dx1[SB-1:0].
  - d4: registered RAM read data.
  - d5:
    - ch_opaque = inside_d5 && pix != TRANSPARENT_COLOR.
    - ch_color = ch_opaque ? pix : 0.
  - d6: lowest-index channel with ch_opaque wins; color = its pixel, opaque = 1; if none, color=0, opaque=0.
- Position wrap-around: counters beyond 2^OFFSET_BITS are truncated; there is no wrap-around of sprite placement.
- Reset mid-frame: the pipeline flushes to 0 immediately. Output is valid 6 cycles after release, once shadows reload at the next (0,0).

Decomposition:
- Shared package constants:
  - ADDR_BITS = 2*SPRITE_SIZE_BITS
  - SCALE_BITS = 4
  - SCALE_DIV_BITS = 8
  - field codes FIELD_X/Y/SCALE/ENABLE = 0..3
  - INDEX_BITS = clog2(NUM_SPRITES)
- Sub-module sprite_channel: one per sprite, instantiated via generate. It holds the staging/shadow registers, the d1–d5 pipeline and its bitmap RAM (the existing single-clock RAM with registered read). The top level holds address decode, the priority mux and the output register.

Test Plan:
- Reset then idle, all enables 0 -> color=0, opaque=0 for a full frame.
- Sprite0: x=100, y=50, scale=8, enable=1, bitmap[0]=0x55, then pass (0,0). Count (100,50) -> color=0x55, opaque=1 exactly 6 cycles later; count (99,50) -> opaque=0; count (164,50) -> opaque=0.
- Magnify: sprite0 scale=7, bitmap[1]=0x22. Counts (102,50) and (103,50) -> color=0x22, since dx1=1.
- Priority and transparency: sprite0 and sprite1 both at (100,50), sprite1 bitmap[0]=0x77.
  - sprite0 pixel 0x55 -> 0x55.
  - Set sprite0 bitmap[0]=TRANSPARENT_COLOR -> 0x77.
- Shadow timing: mid-frame write x=200 -> output still follows x=100 until (0,0). Writing at exactly (0,0) takes effect one frame later.
- Assert reset mid-line while opaque=1 -> color/opaque drop to 0 asynchronously. After release, both stay 0 until shadows reload and sprites are re-enabled.
